// File: rtl/key_scan_debounce_ctrl_if.sv
// Event channel from the key scanner to the voice/note logic.
// valid/ready: an event transfers on a cycle where evt_valid && evt_ready; while valid is high the payload holds steady.
interface key_scan_debounce_ctrl_if #(
  parameter int KW = 3
) ();
  logic          evt_valid;
  logic          evt_ready;
  logic [KW-1:0] evt_key;
  logic          evt_press;

  modport master (output evt_valid, output evt_key, output evt_press, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_press, output evt_ready);
endinterface

// File: rtl/key_scan_debounce_ctrl.sv
// Round-robin key debouncer: one shared engine visits each key per scan tick,
// queues press/release events and tracks the lowest held key for mono playback.
module key_scan_debounce_ctrl #(
  parameter int NUM_KEYS     = 8,
  parameter int CLK_DIV      = 1000,
  parameter int STABLE_TICKS = 4,
  parameter int FIFO_DEPTH   = 4,
  localparam int KW          = $clog2(NUM_KEYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_KEYS-1:0]  keys_in,
  output logic [NUM_KEYS-1:0]  keys_stable,
  key_scan_debounce_ctrl_if.master evt,
  output logic                 note_valid,
  output logic [KW-1:0]        note_key,
  output logic                 overflow,
  input  logic                 clr_overflow,
  output logic                 fsm_state
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [KW-1:0]        idx, idx_nxt;
  logic [CW-1:0]        tick_cnt;
  logic                 tick;
  logic [NUM_KEYS-1:0]  sync1, sync2;
  logic [3:0]           cnt [NUM_KEYS];

  logic                 samp, cur, differ, accept, scan;
  logic [3:0]           cnt_cur;

  logic [KW-1:0]        fifo_key   [FIFO_DEPTH];
  logic                 fifo_press [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr, fill;
  logic                 empty, full, pop, push_ok, drop;
  logic [KW-1:0]        low_key;

  // Two-flop synchronizer and free-running scan tick divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= '0;
      sync2    <= '0;
      tick_cnt <= '0;
    end else begin
      sync1    <= keys_in;
      sync2    <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
    end
  end

  assign tick = (tick_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (tick) begin
        state_nxt = SCAN;
        idx_nxt   = '0;
      end
      SCAN: if (idx == KW'(NUM_KEYS - 1)) state_nxt = IDLE;
            else idx_nxt = idx + KW'(1);
      default: state_nxt = IDLE;
    endcase
  end

  assign fsm_state = state;
  assign scan      = (state == SCAN);
  assign samp      = sync2[idx];
  assign cur       = keys_stable[idx];
  assign cnt_cur   = cnt[idx];
  assign differ    = (samp != cur);
  assign accept    = scan && differ && (cnt_cur == 4'(STABLE_TICKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keys_stable <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
    end else if (scan) begin
      if (!differ) begin
        cnt[idx] <= '0;
      end else if (accept) begin
        cnt[idx]         <= '0;
        keys_stable[idx] <= samp;
      end else begin
        cnt[idx] <= cnt_cur + 4'd1;
      end
    end
  end

  // Event FIFO: a pop in the same cycle frees a slot for a push into a full FIFO.
  assign fill    = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (fill == (AW + 1)'(FIFO_DEPTH));
  assign pop     = evt.evt_valid && evt.evt_ready;
  assign push_ok = accept && (!full || pop);
  assign drop    = accept && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_key[i]   <= '0;
        fifo_press[i] <= 1'b0;
      end
    end else begin
      if (push_ok) begin
        fifo_key[wr_ptr[AW-1:0]]   <= idx;
        fifo_press[wr_ptr[AW-1:0]] <= samp;
        wr_ptr                     <= wr_ptr + (AW + 1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW + 1)'(1);
      if (drop) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign evt.evt_valid = !empty;
  assign evt.evt_key   = empty ? '0 : fifo_key[rd_ptr[AW-1:0]];
  assign evt.evt_press = empty ? 1'b0 : fifo_press[rd_ptr[AW-1:0]];

  always_comb begin
    low_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys_stable[i]) low_key = KW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      note_valid <= 1'b0;
      note_key   <= '0;
    end else begin
      note_valid <= |keys_stable;
      note_key   <= low_key;
    end
  end

endmodule

// File: tb/tb_key_scan_debounce_ctrl.sv
// Scoreboarded bench for key_scan_debounce_ctrl with a 4-key, 16-clock tick,
// 3-sample debounce and 2-entry event FIFO.
module tb_key_scan_debounce_ctrl;
  localparam int NK = 4;
  localparam int CD = 16;
  localparam int ST = 3;
  localparam int FD = 2;
  localparam int KW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] keys_in;
  logic [NK-1:0] keys_stable;
  logic          note_valid;
  logic [KW-1:0] note_key;
  logic          overflow;
  logic          clr_overflow;
  logic          fsm_state;

  key_scan_debounce_ctrl_if #(.KW(KW)) evt ();

  key_scan_debounce_ctrl #(
    .NUM_KEYS(NK), .CLK_DIV(CD), .STABLE_TICKS(ST), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .keys_in(keys_in), .keys_stable(keys_stable),
    .evt(evt.master), .note_valid(note_valid), .note_key(note_key),
    .overflow(overflow), .clr_overflow(clr_overflow), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: {key, press}
  logic [KW:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (rst && evt.evt_valid && evt.evt_ready) begin
      check("evt_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("evt_pop", 32'({evt.evt_key, evt.evt_press}), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_scan();
    for (int i = 0; i < 40 && fsm_state !== 1'b1; i++) cycles(1);
    check("wait_scan", 32'(fsm_state), 1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycles(1);
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    keys_in       = 4'b0100;
    evt.evt_ready = 1'b1;
    clr_overflow  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stable", 32'(keys_stable), 0);
    check("rst_valid", 32'(evt.evt_valid), 0);
    check("rst_key", 32'(evt.evt_key), 0);
    check("rst_note_valid", 32'(note_valid), 0);
    check("rst_note_key", 32'(note_key), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_state", 32'(fsm_state), 0);

    // key 2 held through reset
    rst = 1'b1;
    exp_q.push_back({2'd2, 1'b1});
    cycles(15);
    check("tick_idle", 32'(fsm_state), 0);
    cycles(1);
    check("first_scan", 32'(fsm_state), 1);
    cycles(34);
    check("pre_accept", 32'(keys_stable), 0);
    cycles(1);
    check("k2_stable", 32'(keys_stable), 32'h4);
    check("k2_valid", 32'(evt.evt_valid), 1);
    check("k2_key", 32'(evt.evt_key), 2);
    check("k2_press", 32'(evt.evt_press), 1);
    check("k2_note_lag", 32'(note_valid), 0);
    cycles(1);
    check("k2_note_valid", 32'(note_valid), 1);
    check("k2_note_key", 32'(note_key), 2);
    check("k2_popped", 32'(evt.evt_valid), 0);

    // key 1 bouncing faster than three ticks
    for (int t = 0; t < 6; t++) begin
      keys_in[1] = ~keys_in[1];
      cycles(20);
    end
    check("bounce_stable", 32'(keys_stable), 32'h4);
    check("bounce_valid", 32'(evt.evt_valid), 0);
    check("bounce_overflow", 32'(overflow), 0);

    // release key 2, then press 0,1,3 with consumer stalled
    keys_in[2] = 1'b0;
    exp_q.push_back({2'd2, 1'b0});
    wait_drain(100);
    cycles(2);
    check("k2_rel_stable", 32'(keys_stable), 0);
    check("k2_rel_note", 32'(note_valid), 0);
    check("idle_ready_valid", 32'(evt.evt_valid), 0);
    check("idle_ready_key", 32'(evt.evt_key), 0);
    wait_scan();
    cycles(8);
    evt.evt_ready = 1'b0;
    keys_in = 4'b1011;
    exp_q.push_back({2'd0, 1'b1});
    exp_q.push_back({2'd1, 1'b1});
    cycles(56);
    check("multi_stable", 32'(keys_stable), 32'hb);
    check("multi_overflow", 32'(overflow), 1);
    check("multi_valid", 32'(evt.evt_valid), 1);
    check("multi_head_key", 32'(evt.evt_key), 0);
    check("multi_head_press", 32'(evt.evt_press), 1);
    check("multi_note_valid", 32'(note_valid), 1);
    check("multi_note_key", 32'(note_key), 0);
    evt.evt_ready = 1'b1;
    cycles(3);
    check("multi_drained", exp_q.size(), 0);
    check("multi_empty", 32'(evt.evt_valid), 0);
    check("multi_empty_key", 32'(evt.evt_key), 0);
    check("ovf_sticky", 32'(overflow), 1);
    clr_overflow = 1'b1;
    cycles(1);
    clr_overflow = 1'b0;
    check("ovf_clear", 32'(overflow), 0);

    // keys 0 and 3 held, then key 0 released
    keys_in = 4'b1001;
    exp_q.push_back({2'd1, 1'b0});
    wait_drain(80);
    cycles(2);
    check("k03_stable", 32'(keys_stable), 32'h9);
    check("k03_note_key", 32'(note_key), 0);
    keys_in = 4'b1000;
    exp_q.push_back({2'd0, 1'b0});
    wait_drain(80);
    cycles(2);
    check("k3_stable", 32'(keys_stable), 32'h8);
    check("k3_note_valid", 32'(note_valid), 1);
    check("k3_note_key", 32'(note_key), 3);

    // reset mid-scan with an event pending
    evt.evt_ready = 1'b0;
    keys_in = 4'b0000;
    exp_q.push_back({2'd3, 1'b0});
    for (int i = 0; i < 80 && evt.evt_valid !== 1'b1; i++) cycles(1);
    check("pend_valid", 32'(evt.evt_valid), 1);
    wait_scan();
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(evt.evt_valid), 0);
    check("mid_rst_stable", 32'(keys_stable), 0);
    check("mid_rst_state", 32'(fsm_state), 0);
    exp_q.delete();
    keys_in = 4'b0001;
    cycles(2);
    rst = 1'b1;
    evt.evt_ready = 1'b1;
    exp_q.push_back({2'd0, 1'b1});
    cycles(48);
    check("fresh_pre", 32'(keys_stable), 0);
    cycles(1);
    check("fresh_stable", 32'(keys_stable), 32'h1);
    check("fresh_valid", 32'(evt.evt_valid), 1);
    wait_drain(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_scan_debounce_ctrl.md
Name: key_scan_debounce_ctrl

Overview:
- Scheduler that time-shares one debounce engine across NUM_KEYS raw keyboard inputs in round-robin order.
- Keeps per-key stability counters and the debounced key state.
- Reports press/release events to the voice/note logic through a valid/ready FIFO.
- Also outputs a lowest-index held-key note for monophonic playback.
- Sits between the board key pins and the synthesizer tone generator.

Parameters:
- NUM_KEYS, 8: number of key inputs; 2..16.
- CLK_DIV, 1000: clocks per scan tick; must be greater than NUM_KEYS.
- STABLE_TICKS, 4: consecutive differing samples required to accept a change; 2..15.
- FIFO_DEPTH, 4: event FIFO entries; power of two, at least 2.
- KW (localparam), clog2(NUM_KEYS): key index width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- keys_in  in  NUM_KEYS  raw, asynchronous, bouncing key pins; 1 = pressed
- keys_stable  out  NUM_KEYS  debounced key state
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts the head event
- evt_key  out  KW  key index of the head event
- evt_press  out  1  1 = press, 0 = release
- note_valid  out  1  at least one key is held in keys_stable
- note_key  out  KW  lowest index set in keys_stable
- overflow  out  1  sticky: an event was dropped
- clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (rst = 0, asynchronous):
  - Synchronizers, counters, keys_stable, FIFO pointers, overflow, note_valid and note_key all go to 0.
  - evt_valid = 0. FSM goes to IDLE. Tick counter goes to 0.
- Synchronizer: each keys_in bit passes through a 2-flop chain. Only the synchronized value is used.
- Tick counter:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick pulses for one cycle when the count equals CLK_DIV-1.
  - Runs in every state.
- FSM:
  - IDLE: on tick, set idx = 0 and go to SCAN.
  - SCAN: services key idx in one cycle. If idx == NUM_KEYS-1, go to IDLE; otherwise idx++.
  - A scan pass takes exactly NUM_KEYS cycles.
  - A tick during SCAN cannot occur, because CLK_DIV > NUM_KEYS.
- Per-key service, where s = synchronized sample and k = keys_stable[idx]:
  - s == k: cnt[idx] = 0.
  - s != k and cnt[idx] < STABLE_TICKS-1: cnt[idx]++.
  - s != k and cnt[idx] == STABLE_TICKS-1: keys_stable[idx] = s, cnt[idx] = 0, and push event {idx, s}.
  - Counters are 4 bits.
- Latency:
  - A clean level change is accepted on the STABLE_TICKS-th consecutive scan that sees it.
  - keys_stable updates the cycle after that key's scan slot.
  - evt_valid rises in the same cycle keys_stable updates, if the FIFO was empty.
- Event FIFO:
  - Pop when evt_valid && evt_ready. evt_key/evt_press always show the head entry; they are 0 when empty.
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Push to a full FIFO with no pop: the event is dropped and overflow is set. keys_stable still updates.
  - overflow clears on clr_overflow. If a drop and clr_overflow coincide, set wins.
  - Order is strictly the order in which events were generated.
- Note output:
  - Registered: computed from keys_stable each cycle, so it lags keys_stable by one cycle.
  - note_valid = |keys_stable.
  - note_key = lowest set index, or 0 when none is set.
- Boundaries:
  - A bounce that returns to k before the count completes resets cnt with no event.
  - Multiple keys toggling in one pass produce events in ascending index order.
  - Reset mid-scan abandons the pass; no partial event remains.
  - evt_ready held high with an empty FIFO has no effect.

Test Plan (NUM_KEYS=4, CLK_DIV=16, STABLE_TICKS=3, FIFO_DEPTH=2):
- Reset release: all outputs 0; the first SCAN starts in the cycle after the count reaches 15 (cycle 16).
- Key 2 held high from time 0 with evt_ready=1 -> keys_stable=4'b0100 after the third tick's slot 2; one event {2,press}; note_valid=1, note_key=2 one cycle later.
- Key 1 toggling every 20 cycles (shorter than 3 ticks) -> no events, keys_stable[1] stays 0.
- Keys 0, 1, 3 pressed together with evt_ready=0 -> FIFO holds {0,press} then {1,press}; {3} is dropped, overflow=1, keys_stable=4'b1011. Then evt_ready=1 pops the two events in order; clr_overflow clears the flag.
- Keys 0 and 3 held, then key 0 released -> {0,release} event; note_key changes from 0 to 3.
- rst asserted mid-SCAN with a pending FIFO entry -> evt_valid=0 and keys_stable=0 immediately; the next accepted event needs 3 fresh ticks.
